// File: rtl/mem_responder.sv
// Unified instruction/data memory slave for the multicycle controller.
// Each request is accepted only in IDLE. It is held for WAIT_CYCLES wait
// states and then completes in a single RESP cycle, during which ready=1.
// A misaligned or out-of-range address completes with err=1, rd=0 and no write.
module mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      cnt;

    // Request captured at acceptance. Only the word index is kept, because
    // the fault decision is made on the full address at that point.
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wd;
    logic            lat_we;
    logic            lat_fault;

    logic [31:0]     mem [DEPTH];

    logic            fault_in;
    logic [AW-1:0]   cur_idx;
    logic            cur_we;
    logic            cur_fault;

    // Fault check on the incoming address: misaligned, or beyond the array.
    assign fault_in = (adr[1:0] != 2'b00) || (adr[31:2] >= 30'(DEPTH));

    // Access being completed. With zero wait states RESP follows IDLE
    // directly, so the response must be formed from the live request.
    always_comb begin
        cur_idx   = lat_idx;
        cur_we    = lat_we;
        cur_fault = lat_fault;
        if (state == S_IDLE) begin
            cur_idx   = adr[AW+1:2];
            cur_we    = we;
            cur_fault = fault_in;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (req) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (cnt <= 4'd1) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Wait-state counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (state == S_IDLE && req) begin
            cnt <= 4'(WAIT_CYCLES);
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Request latch. This is pure datapath, and the FSM qualifies every use.
    // NOTE: registers whose value is only consumed under a state qualifier need no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            lat_idx   <= adr[AW+1:2];
            lat_wd    <= wd;
            lat_we    <= we;
            lat_fault <= fault_in;
        end
    end

    // Response registers, loaded on the edge that enters RESP. rd changes
    // only for reads, faults and reset. err lasts only for the RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd  <= 32'd0;
            err <= 1'b0;
        end else if (state_next == S_RESP) begin
            if (cur_fault) begin
                rd  <= 32'd0;
                err <= 1'b1;
            end else begin
                err <= 1'b0;
                if (!cur_we) rd <= mem[cur_idx];
            end
        end else begin
            err <= 1'b0;
        end
    end

    // Write commit at the end of RESP. A reset on that edge discards it.
    // NOTE: the memory array is never reset; reset only aborts the access in flight.
    always_ff @(posedge clk) begin
        if (reset && state == S_RESP && lat_we && !lat_fault)
            mem[lat_idx] <= lat_wd;
    end

    // Status outputs are decoded from the state register only.
    assign ready = (state == S_RESP);
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder. Two instances are used: one with the
// default wait states and one with zero wait states. The driver pushes the
// expected response and its completion cycle. Per-instance monitors pop an
// entry whenever ready is seen.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, we_a, req_z, we_z;
    logic [31:0] adr_a, wd_a, adr_z, wd_z;
    logic [31:0] rd_a, rd_z;
    logic        ready_a, err_a, busy_a, ready_z, err_z, busy_z;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    exp_t q_a[$];
    exp_t q_z[$];
    exp_t e_a, e_z;

    mem_responder dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .adr(adr_a), .wd(wd_a),
        .rd(rd_a), .ready(ready_a), .err(err_a), .busy(busy_a)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .req(req_z), .we(we_z), .adr(adr_z), .wd(wd_z),
        .rd(rd_z), .ready(ready_z), .err(err_z), .busy(busy_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready_a) begin
                if (q_a.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_unexpected_ready: got ready=1, expected no response (cycle %0d)", cyc);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_latency", cyc, e_a.cyc);
                    check("a_err", {31'd0, err_a}, {31'd0, e_a.err});
                    check("a_rd", rd_a, e_a.rd);
                end
            end else begin
                check("a_err_outside_resp", {31'd0, err_a}, 32'd0);
            end
        end
    end

    // Monitor for the zero-wait instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready_z) begin
                if (q_z.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL z_unexpected_ready: got ready=1, expected no response (cycle %0d)", cyc);
                end else begin
                    e_z = q_z.pop_front();
                    check("z_latency", cyc, e_z.cyc);
                    check("z_err", {31'd0, err_z}, {31'd0, e_z.err});
                    check("z_rd", rd_z, e_z.rd);
                end
            end else begin
                check("z_err_outside_resp", {31'd0, err_z}, 32'd0);
            end
        end
    end

    // Wait until the scoreboard has drained, then one more cycle so the
    // DUT is back in IDLE before the next request is raised.
    task automatic wait_done(input bit z);
        int n = 0;
        while (((z ? q_z.size() : q_a.size()) != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((z ? q_z.size() : q_a.size()) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no ready within 40 cycles, expected a response", z ? "z" : "a");
            if (z) q_z.delete();
            else   q_a.delete();
        end
        @(negedge clk);
    endtask

    // Issue one request, push its expected response, and wait for completion.
    task automatic do_req(input bit z, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        @(negedge clk);
        if (z) begin req_z = 1'b1; we_z = w; adr_z = a; wd_z = d; end
        else   begin req_a = 1'b1; we_a = w; adr_a = a; wd_a = d; end
        @(posedge clk);
        #1;
        e.rd  = exp_rd;
        e.err = exp_err;
        e.cyc = cyc + (z ? 0 : 2);
        if (z) begin q_z.push_back(e); req_z = 1'b0; end
        else   begin q_a.push_back(e); req_a = 1'b0; end
        wait_done(z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        req_a = 1'b0; we_a = 1'b0; adr_a = 32'd0; wd_a = 32'd0;
        req_z = 1'b0; we_z = 1'b0; adr_z = 32'd0; wd_z = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("reset_ready", {31'd0, ready_a}, 32'd0);
        check("reset_err",   {31'd0, err_a},   32'd0);
        check("reset_busy",  {31'd0, busy_a},  32'd0);
        check("reset_rd",    rd_a,             32'd0);
        mon_en = 1'b1;

        // Write then read back; a write leaves rd at its previous value.
        do_req(1'b0, 1'b1, 32'h10, 32'hE281_1001, 32'h0000_0000, 1'b0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0,         32'hE281_1001, 1'b0);
        // Misaligned read faults with rd=0; the word is not disturbed.
        do_req(1'b0, 1'b0, 32'h13, 32'h0,         32'h0000_0000, 1'b1);
        do_req(1'b0, 1'b0, 32'h10, 32'h0,         32'hE281_1001, 1'b0);
        // Out-of-range write faults; word 0 keeps its contents.
        do_req(1'b0, 1'b1, 32'h0,   32'hA5A5_0000, 32'hE281_1001, 1'b0);
        do_req(1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        do_req(1'b0, 1'b0, 32'h0,   32'h0,         32'hA5A5_0000, 1'b0);
        // Last legal word, and read-after-write of the preceding request.
        do_req(1'b0, 1'b1, 32'hFC, 32'h0BAD_F00D, 32'hA5A5_0000, 1'b0);
        do_req(1'b0, 1'b0, 32'hFC, 32'h0,         32'h0BAD_F00D, 1'b0);
        do_req(1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'h0BAD_F00D, 1'b0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0,         32'h1234_5678, 1'b0);

        // Reset during WAIT of a write: no response, and the write is dropped.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; adr_a = 32'h20; wd_a = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        check("abort_busy_in_wait", {31'd0, busy_a}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy",  {31'd0, busy_a},  32'd0);
        check("abort_ready", {31'd0, ready_a}, 32'd0);
        check("abort_rd",    rd_a,             32'd0);
        repeat (4) @(negedge clk);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);

        // Zero wait states: preload word 0, then hold req high for 6 edges.
        do_req(1'b1, 1'b1, 32'h0, 32'h600D_CAFE, 32'h0000_0000, 1'b0);
        @(negedge clk);
        req_z = 1'b1; we_z = 1'b0; adr_z = 32'h0;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.rd  = 32'h600D_CAFE;
            e.err = 1'b0;
            e.cyc = cyc + 1 + 2 * i;
            q_z.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("z_busy_toggle", {31'd0, busy_z}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        req_z = 1'b0;
        wait_done(1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory that services the multicycle controller's memory accesses: instruction fetch, LDR and STR.
- The controller/datapath issues one request at a time. This block accepts it, holds it for a fixed number of wait states, then completes the access and returns a one-cycle ready pulse.
- It sits between the datapath address mux (AdrSrc) and the instruction/data register inputs. It is the slave end of the memory interface the controller drives.

Parameters:
- DEPTH, 64, number of 32-bit words stored; word index = adr[31:2].
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk    input   1   system clock; all logic is rising-edge.
- reset  input   1   synchronous, active-low reset (asserted when 0, sampled on rising clk).
- req    input   1   access request; sampled only in IDLE.
- we     input   1   1 = write (STR), 0 = read (fetch/LDR); sampled with req.
- adr    input   32  byte address; sampled with req.
- wd     input   32  write data; sampled with req.
- rd     output  32  read data; valid when ready=1 on a read response.
- ready  output  1   one-cycle completion pulse.
- err    output  1   asserted together with ready when the access faulted.
- busy   output  1   1 whenever the state is not IDLE.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, ready=0, err=0, busy=0, rd=0, wait counter=0.
  - Memory array contents are NOT cleared.
  - A reset during WAIT or RESP aborts the access; a pending write is discarded.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req=1, latch adr/we/wd and load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - With req=0, stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, next state is RESP.
  - req/we/adr/wd are ignored.
- RESP: lasts exactly one cycle, then IDLE. During this cycle ready=1.
  - Read, legal address: rd = mem[adr[31:2]], err=0.
  - Write, legal address: mem[adr[31:2]] updated at the end of the RESP cycle, err=0; rd holds its previous value.
  - Fault (adr[1:0]!=0, or adr[31:2]>=DEPTH): err=1, no write occurs, rd=0.
- Latency: a req sampled at edge k gives ready=1 in cycle k+1+WAIT_CYCLES. This is 1 cycle for WAIT_CYCLES=0 and 3 cycles for the default.
- Back-to-back requests:
  - req is sampled only in IDLE. The earliest next acceptance is the edge ending the cycle after RESP.
  - req held high continuously therefore yields one access every WAIT_CYCLES+2 cycles.
- rd holds its value outside read responses. It changes only on a read RESP, a fault RESP, or reset.
- A read of a word written by the immediately preceding request returns the new data.
- busy=1 in WAIT and RESP. ready and err are 0 in IDLE and WAIT.
- No combinational path from inputs to outputs; all outputs are registered or decoded from the state.

Test Plan:
- Reset with reset=0 for 2 cycles, then 1 → ready=0, err=0, busy=0, rd=0, state IDLE.
- Write then read, default WAIT_CYCLES=2:
  - req=1, we=1, adr=0x10, wd=0xE2811001 at edge 0 → ready=1 in cycle 3, err=0.
  - Then req=1, we=0, adr=0x10 → ready=1 three cycles after acceptance, rd=0xE2811001.
- Misaligned read, adr=0x13 → ready=1 with err=1, rd=0. A following read of 0x10 still returns the prior contents (no corruption).
- Out-of-range write, adr=0x100 with DEPTH=64 → err=1. A read of word 0 shows no change.
- WAIT_CYCLES=0 with req held high for 6 cycles of reads at adr=0x0 → ready pulses every 2nd cycle, busy toggles 1/0.
- Reset asserted during WAIT of a write to 0x20 with wd=0xDEADBEEF → no ready pulse, busy=0 after reset. A later read of 0x20 returns the old value.
